// File: rtl/deadlock_mon_pkg.sv
// Shared definitions for the kernel deadlock monitors: default sizes,
// the monitor state encoding and the deadlock-candidate function.
package deadlock_mon_pkg;

    localparam int DEF_N_AXIS    = 2;
    localparam int DEF_N_INST    = 3;
    localparam int DEF_N_BLK     = 1;
    localparam int DEF_THRESHOLD = 16;
    localparam int DEF_CNT_W     = 16;

    // Vectors are zero-extended to this width before calling calc_cand.
    localparam int MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        DEADLOCK = 2'd2
    } mon_state_t;

    // A kernel is a deadlock candidate when it is busy, every child is either
    // idle or stalled on its stream, and at least one stall flag is set.
    // Child i owns axis[i-1]; idle[0] is the parent.
    function automatic logic calc_cand(
        input logic [MAX_W-1:0] axis,
        input logic [MAX_W-1:0] idle,
        input logic [MAX_W-1:0] blk,
        input int               n_inst
    );
        logic all_quiet;
        all_quiet = 1'b1;
        for (int i = 1; i < MAX_W; i++) begin
            if (i < n_inst) begin
                all_quiet = all_quiet & (idle[i] | axis[i-1]);
            end
        end
        return ~idle[0] & all_quiet & ((|axis) | (|blk));
    endfunction

endpackage

// File: rtl/deadlock_persist_counter.sv
// Counts consecutive cycles with cand high. hit flags the cycle in which the
// count would reach THRESHOLD; the count then holds at THRESHOLD-1.
module deadlock_persist_counter
    import deadlock_mon_pkg::*;
#(
    parameter int THRESHOLD = DEF_THRESHOLD,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic clock,
    input  logic reset,
    input  logic cand,
    input  logic freeze,
    output logic hit
);

    logic [CNT_W-1:0] cnt;

    assign hit = cand & (cnt == CNT_W'(THRESHOLD - 1));

    // Any cycle without cand restarts the run; freeze keeps the count once the
    // owner has latched its deadlock flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!freeze) begin
            if (!cand) begin
                cnt <= '0;
            end else if (!hit) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/deadlock_kernel_idx0_monitor.sv
// Deadlock monitor for kernel instance 0. Raises a sticky block flag after
// THRESHOLD consecutive cycles of a busy kernel whose children are all idle
// or stalled with at least one genuine stall.
module deadlock_kernel_idx0_monitor
    import deadlock_mon_pkg::*;
#(
    parameter int N_AXIS    = DEF_N_AXIS,
    parameter int N_INST    = DEF_N_INST,
    parameter int N_BLK     = DEF_N_BLK,
    parameter int THRESHOLD = DEF_THRESHOLD,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_INST-1:0] inst_idle_sigs,
    input  logic [N_BLK-1:0]  inst_block_sigs,
    output logic              block
);

    logic [MAX_W-1:0] axis_ext;
    logic [MAX_W-1:0] idle_ext;
    logic [MAX_W-1:0] blk_ext;
    logic             cand;
    logic             hit;
    mon_state_t       state;

    assign axis_ext = MAX_W'(axis_block_sigs);
    assign idle_ext = MAX_W'(inst_idle_sigs);
    assign blk_ext  = MAX_W'(inst_block_sigs);
    assign cand     = calc_cand(axis_ext, idle_ext, blk_ext, N_INST);

    deadlock_persist_counter #(
        .THRESHOLD (THRESHOLD),
        .CNT_W     (CNT_W)
    ) u_persist (
        .clock  (clock),
        .reset  (reset),
        .cand   (cand),
        .freeze (block),
        .hit    (hit)
    );

    // Monitor FSM; DEADLOCK is absorbing and block is its registered output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            block <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        state <= DEADLOCK;
                        block <= 1'b1;
                    end else if (cand) begin
                        state <= COUNTING;
                    end
                end
                COUNTING: begin
                    if (hit) begin
                        state <= DEADLOCK;
                        block <= 1'b1;
                    end else if (!cand) begin
                        state <= IDLE;
                    end
                end
                DEADLOCK: begin
                    state <= DEADLOCK;
                    block <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    block <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deadlock_kernel_idx0_monitor.sv
// Directed bench: THRESHOLD=4 instance for the main plan, a THRESHOLD=1
// instance sharing the stimulus but with its own reset.
module tb_deadlock_kernel_idx0_monitor;

    logic       clock;
    logic       reset;
    logic       reset1;
    logic [1:0] axis_block_sigs;
    logic [2:0] inst_idle_sigs;
    logic [0:0] inst_block_sigs;
    logic       block;
    logic       block1;

    int n_cmp = 0;
    int n_err = 0;

    deadlock_kernel_idx0_monitor #(
        .N_AXIS (2), .N_INST (3), .N_BLK (1), .THRESHOLD (4), .CNT_W (16)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .axis_block_sigs (axis_block_sigs),
        .inst_idle_sigs  (inst_idle_sigs),
        .inst_block_sigs (inst_block_sigs),
        .block           (block)
    );

    deadlock_kernel_idx0_monitor #(
        .N_AXIS (2), .N_INST (3), .N_BLK (1), .THRESHOLD (1), .CNT_W (16)
    ) dut1 (
        .clock           (clock),
        .reset           (reset1),
        .axis_block_sigs (axis_block_sigs),
        .inst_idle_sigs  (inst_idle_sigs),
        .inst_block_sigs (inst_block_sigs),
        .block           (block1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] idle, input logic [1:0] axis, input logic blk);
        inst_idle_sigs     = idle;
        axis_block_sigs    = axis;
        inst_block_sigs[0] = blk;
    endtask

    // Synchronous-style reset pulse spanning one rising edge.
    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        reset1 = 1'b1;
        drive(3'b000, 2'b00, 1'b0);
        repeat (2) @(negedge clock);
        check("reset_block", block, 1'b0);
        check("reset_block_t1", block1, 1'b0);
        reset = 1'b0;

        // Quiet inputs never raise block.
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            check("quiet", block, 1'b0);
        end

        // Persistent deadlock: rises after edge 4, then sticky.
        drive(3'b010, 2'b10, 1'b0);
        for (int e = 1; e <= 3; e++) begin
            @(negedge clock);
            check("persist_pre", block, 1'b0);
        end
        @(negedge clock);
        check("persist_edge4", block, 1'b1);
        drive(3'b000, 2'b00, 1'b0);
        repeat (5) @(negedge clock);
        check("persist_sticky", block, 1'b1);
        // Async reset clears block without a clock edge.
        #1 reset = 1'b1;
        #1 check("async_clr_block", block, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        check("after_async_clr", block, 1'b0);

        // Broken run: one non-candidate cycle restarts the count.
        drive(3'b010, 2'b10, 1'b0);
        for (int e = 1; e <= 3; e++) begin
            @(negedge clock);
            check("broken_pre", block, 1'b0);
        end
        drive(3'b010, 2'b00, 1'b0);
        @(negedge clock);
        check("broken_gap", block, 1'b0);
        drive(3'b010, 2'b10, 1'b0);
        for (int e = 1; e <= 3; e++) begin
            @(negedge clock);
            check("broken_restart", block, 1'b0);
        end
        @(negedge clock);
        check("broken_edge4", block, 1'b1);
        pulse_reset();

        // Idle parent masks any stall.
        drive(3'b011, 2'b10, 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            check("parent_idle", block, 1'b0);
        end
        // Children idle but nothing blocked.
        drive(3'b110, 2'b00, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("idle_no_blk", block, 1'b0);
        end

        // Partial stall: child 2 still active.
        drive(3'b000, 2'b01, 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            check("partial_stall", block, 1'b0);
        end
        // Parent internal-channel stall with idle children.
        drive(3'b110, 2'b00, 1'b1);
        for (int e = 1; e <= 3; e++) begin
            @(negedge clock);
            check("inst_blk_pre", block, 1'b0);
        end
        @(negedge clock);
        check("inst_blk_edge4", block, 1'b1);
        pulse_reset();

        // Async reset with cnt=2: count must restart from zero.
        drive(3'b010, 2'b10, 1'b0);
        repeat (2) @(negedge clock);
        check("mid_cnt_pre", block, 1'b0);
        #1 reset = 1'b1;
        #1 check("mid_cnt_rst", block, 1'b0);
        reset = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(negedge clock);
            check("mid_cnt_restart", block, 1'b0);
        end
        @(negedge clock);
        check("mid_cnt_edge4", block, 1'b1);
        pulse_reset();

        // Same child both idle and stream-blocked still counts.
        drive(3'b110, 2'b10, 1'b0);
        for (int e = 1; e <= 3; e++) begin
            @(negedge clock);
            check("overlap_pre", block, 1'b0);
        end
        @(negedge clock);
        check("overlap_edge4", block, 1'b1);
        pulse_reset();

        // THRESHOLD=1 instance: rises on the first candidate edge.
        drive(3'b000, 2'b00, 1'b0);
        reset1 = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("t1_quiet", block1, 1'b0);
        end
        drive(3'b010, 2'b10, 1'b0);
        @(negedge clock);
        check("t1_edge1", block1, 1'b1);
        check("t4_edge1", block, 1'b0);
        drive(3'b000, 2'b00, 1'b0);
        @(negedge clock);
        check("t1_sticky", block1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
